// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK flop-bank arbiter: opcodes, FSM states and
// per-bit J/K encode / readback-expectation helpers.
package jk_bank_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    // Returns {j, k} for one bit; unmasked bits leave the flop alone.
    function automatic logic [1:0] jk_encode(input logic [1:0] op, input logic mask);
        logic [1:0] jk;
        jk = 2'b00;
        if (mask) begin
            case (op)
                OP_CLEAR:  jk = 2'b01;
                OP_SET:    jk = 2'b10;
                OP_TOGGLE: jk = 2'b11;
                default:   jk = 2'b00;
            endcase
        end
        return jk;
    endfunction

    // Value one bit should hold after the operation, given its prior value.
    function automatic logic jk_expect(input logic [1:0] op, input logic mask,
                                       input logic q_pre);
        logic q;
        q = q_pre;
        if (mask) begin
            case (op)
                OP_CLEAR:  q = 1'b0;
                OP_SET:    q = 1'b1;
                OP_TOGGLE: q = ~q_pre;
                default:   q = q_pre;
            endcase
        end
        return q;
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around to index 0.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    // Scan from the farthest offset down so the closest match to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flop bank among N_REQ requesters.
// Optional readback checking is built when JK_BANK_ARBITER_VERIFY_EN is defined.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] mask,
    input  logic [WIDTH-1:0]       q_in,
    output logic [WIDTH-1:0]       j_out,
    output logic [WIDTH-1:0]       k_out,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rdata,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   err
);

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] mask_lat;
    logic             arb_valid;
    logic [IDW-1:0]   arb_id;
    logic             take_grant;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .req        (req),
        .ptr        (ptr),
        .grant_valid(arb_valid),
        .grant_id   (arb_id)
    );

    assign take_grant = (state == S_IDLE) && arb_valid;
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (arb_valid) state_next = S_DRIVE;
            S_DRIVE:  state_next = S_SETTLE;
            S_SETTLE: state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // J/K are live only during DRIVE; the bank captures them on the edge leaving it.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (state == S_DRIVE) begin
            for (int b = 0; b < WIDTH; b++) begin
                {j_out[b], k_out[b]} = jk_encode(op_lat, mask_lat[b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            op_lat   <= OP_HOLD;
            mask_lat <= '0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                grant_id <= arb_id;
                op_lat   <= op[2*int'(arb_id) +: 2];
                mask_lat <= mask[WIDTH*int'(arb_id) +: WIDTH];
            end
            if (state == S_ACK) begin
                if (int'(grant_id) == N_REQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_id + 1'b1;
                end
            end
        end
    end

    // Ack and readback are registered on entry to ACK so rdata is valid with ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack   <= '0;
            rdata <= '0;
        end else begin
            ack <= '0;
            if (state == S_SETTLE) begin
                ack[grant_id] <= 1'b1;
                rdata         <= q_in;
            end
        end
    end

`ifdef JK_BANK_ARBITER_VERIFY_EN
    logic [WIDTH-1:0] q_pre;
    logic [WIDTH-1:0] q_exp;

    always_comb begin
        q_exp = '0;
        for (int b = 0; b < WIDTH; b++) begin
            q_exp[b] = jk_expect(op_lat, mask_lat[b], q_pre[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_pre <= '0;
            err   <= 1'b0;
        end else begin
            if (take_grant) begin
                q_pre <= q_in;
            end
            if ((state == S_ACK) && (q_in != q_exp)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK flip-flops (existing JK functional flop, one per bit) among N_REQ requesters.
- Each requester issues one bank operation per transaction: HOLD, CLEAR, SET or TOGGLE, with a per-bit mask.
- The block grants requesters round-robin, sequences the J/K drive, waits for the bank to settle, and returns an ack with readback.
- Sits between requester logic and the flop bank. It is the sole driver of the bank's J/K inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK flops in the bank.
- IDW, derived localparam $clog2(N_REQ), width of the grant id.

Ports:
- clk  input  1  system clock; the flop bank uses the same clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held until that requester's ack.
- op  input  2*N_REQ  per-requester opcode; requester i uses bits [2i+1:2i].
- mask  input  WIDTH*N_REQ  per-requester bit mask; requester i uses slice i.
- q_in  input  WIDTH  Q outputs of the flop bank.
- j_out  output  WIDTH  J inputs to the bank.
- k_out  output  WIDTH  K inputs to the bank.
- ack  output  N_REQ  one-hot, one-cycle completion pulse.
- rdata  output  WIDTH  bank value captured at ack; valid while ack is asserted and held afterwards.
- grant_id  output  IDW  id of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky readback-mismatch flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): all outputs are 0 on the next edge, state is IDLE, round-robin pointer is 0.
- Reset asserted mid-transaction aborts it: no ack is issued, j_out/k_out go to 0, latched op/mask are discarded.
- Opcode encoding, per masked bit:
  - 00 HOLD: J=0, K=0.
  - 01 CLEAR: J=0, K=1.
  - 10 SET: J=1, K=0.
  - 11 TOGGLE: J=1, K=1.
  - Unmasked bits always get J=K=0.
- States: IDLE, DRIVE, SETTLE, ACK.
- IDLE:
  - j_out=k_out=0.
  - If any req is high, pick the first requester found scanning from ptr upward with wrap-around.
  - Latch its op and mask, update grant_id, go to DRIVE. Otherwise stay in IDLE.
- DRIVE: j_out/k_out are driven from the latched op and mask for exactly one cycle. The bank captures them on the edge that leaves DRIVE. Next state: SETTLE.
- SETTLE: j_out=k_out=0 for one cycle, so q_in reflects the update. Next state: ACK.
- ACK:
  - ack[grant_id]=1 for one cycle; rdata<=q_in.
  - ptr<=(grant_id+1) mod N_REQ; next state IDLE.
- Latency: req sampled in IDLE at edge t gives ack high in cycle t+3. Back-to-back throughput is one transaction per 4 cycles.
- Requester rules:
  - A requester must deassert req in the cycle after its ack unless it wants another transaction.
  - If req stays high, that requester is re-arbitrated behind the others because ptr has already advanced.
- req dropped after grant: the transaction completes using latched values and ack is still issued.
- op/mask changing after grant has no effect.
- HOLD op or all-zero mask: the full 4-cycle sequence still runs, ack is issued, and the bank is unchanged.
- Simultaneous requests: exactly one grant per transaction. No requester is starved; worst-case wait is N_REQ transactions.

Optional Feature:
- Macro: JK_BANK_ARBITER_VERIFY_EN.
- With the macro defined:
  - On grant, snapshot q_in as q_pre.
  - In ACK, compute expected per bit: the masked op applied to q_pre (HOLD keeps, CLEAR gives 0, SET gives 1, TOGGLE inverts); unmasked bits keep q_pre.
  - If q_in differs from expected, set err. err stays set until reset.
- Without the macro: err is tied to 0 and no snapshot or compare logic is built.

Decomposition:
- Package jk_bank_pkg:
  - Opcode constants OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE.
  - FSM state encoding S_IDLE, S_DRIVE, S_SETTLE, S_ACK.
  - Function jk_encode(op, mask) returning {j,k}.
  - Function jk_expect(op, mask, q_pre).
- Sub-module rr_arbiter (parameter N), purely combinational:
  - Inputs: req, ptr.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Reset with req=4'b1111 held: all outputs 0 and no ack for 5 cycles. Release reset: first ack is ack[0] at cycle 3, then ack[1], ack[2], ack[3], ack[0], each 4 cycles apart.
- Bank=0x00; req0 SET mask 0x0F; then req1 TOGGLE mask 0xFF; then req2 CLEAR mask 0xF0. Expected rdata: 0x0F, then 0xF0, then 0x00.
- req3 HOLD mask 0xFF with bank=0xA5: ack[3] at cycle 3 and rdata=0xA5. Also check j_out/k_out are never nonzero.
- req1 pulsed for 1 cycle only, op TOGGLE mask 0x01, bank=0x00: transaction completes, ack[1] pulses, rdata=0x01.
- Reset asserted in the SETTLE state of a SET 0xFF transaction: no ack, busy=0 next cycle, ptr=0. A new req2 is then granted with grant_id=2.
- With JK_BANK_ARBITER_VERIFY_EN, the bench model forces bit 0 stuck at 0 during SET mask 0x01: err=1 after ack and stays 1 until reset. Without the macro, err stays 0.
